// File: rtl/motor_ctrl_pkg.sv
// Shared definitions for the PWM motor driver: FSM encoding, default timing
// constants and the command magnitude helper.
package motor_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DEAD  = 2'd2
   } motor_state_e;

   localparam int PERIOD_DEF   = 1000;
   localparam int MAX_DUTY_DEF = 950;
   localparam int DEADTIME_DEF = 8;

   // 17 bits so that |-32768| is representable without wrapping
   function automatic logic [16:0] cmd_magnitude(input logic [15:0] cmd);
      logic [16:0] ext;
      ext = {cmd[15], cmd};
      return cmd[15] ? (17'd0 - ext) : ext;
   endfunction

endpackage

// File: rtl/pwm_motor_driver_if.sv
// Command and gate-drive signals between the PD controller and the motor
// driver.
interface pwm_motor_driver_if;

   logic [15:0] cmd_in;
   logic        cmd_valid;
   logic        pwm_a;
   logic        pwm_b;
   logic        dir;
   logic        sat_flag;
   logic        period_start;

   modport master (
      output cmd_in, cmd_valid,
      input  pwm_a, pwm_b, dir, sat_flag, period_start
   );

   modport slave (
      input  cmd_in, cmd_valid,
      output pwm_a, pwm_b, dir, sat_flag, period_start
   );

endinterface

// File: rtl/pwm_period_counter.sv
// Free-running PWM period counter 0..PERIOD-1 with a start flag at 0 and a
// load strobe on the last count.
module pwm_period_counter #(
   parameter int PERIOD = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] cnt_o,
   output logic        period_start_o,
   output logic        load_o
);

   localparam logic [15:0] LAST = 16'(PERIOD - 1);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? 16'd0 : cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o          = cnt_q;
   assign period_start_o = (cnt_q == 16'd0);
   assign load_o         = (cnt_q == LAST);

endmodule

// File: rtl/pwm_motor_driver.sv
// H-bridge PWM driver: shadow/active command registers with duty clamp and a
// direction FSM that inserts dead time on reversal.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | magnitude zero, both gates held low
// ST_DRIVE | gate for active dir high while cnt < mag
// ST_DEAD  | reversal in progress, both gates low for DEADTIME cycles
module pwm_motor_driver
   import motor_ctrl_pkg::*;
#(
   parameter int PERIOD   = PERIOD_DEF,
   parameter int MAX_DUTY = MAX_DUTY_DEF,
   parameter int DEADTIME = DEADTIME_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   pwm_motor_driver_if.slave bus
);

   localparam logic [15:0] MAX_D   = 16'(MAX_DUTY);
   localparam logic [15:0] DEAD_LD = 16'(DEADTIME);

   logic [15:0] cnt;
   logic        period_start;
   logic        load;

   logic [16:0] cmd_abs;
   logic [15:0] cmd_mag;
   logic        cmd_sat;

   motor_state_e state_q, state_d;
   logic [15:0]  smag_q, smag_d;
   logic         sdir_q, sdir_d;
   logic         ssat_q, ssat_d;
   logic [15:0]  mag_q, mag_d;
   logic         dir_q, dir_d;
   logic         sat_q, sat_d;
   logic [15:0]  dead_q, dead_d;
   logic         pwm_a_q, pwm_a_d;
   logic         pwm_b_q, pwm_b_d;

   pwm_period_counter #(
      .PERIOD(PERIOD)
   ) u_cnt (
      .clk           (clk),
      .rst_n         (rst_n),
      .cnt_o         (cnt),
      .period_start_o(period_start),
      .load_o        (load)
   );

   always_comb begin
      cmd_abs = cmd_magnitude(bus.cmd_in);
      cmd_sat = (cmd_abs > {1'b0, MAX_D});
      cmd_mag = cmd_sat ? MAX_D : cmd_abs[15:0];
   end

   always_comb begin
      smag_d  = smag_q;
      sdir_d  = sdir_q;
      ssat_d  = ssat_q;
      mag_d   = mag_q;
      dir_d   = dir_q;
      sat_d   = sat_q;
      state_d = state_q;
      dead_d  = dead_q;

      if (bus.cmd_valid) begin
         smag_d = cmd_mag;
         sdir_d = bus.cmd_in[15];
         ssat_d = cmd_sat;
      end

      if (state_q == ST_DEAD) begin
         if (dead_q > 16'd1) begin
            dead_d = dead_q - 16'd1;
         end else begin
            dead_d  = '0;
            state_d = ST_DRIVE;
         end
      end

      // load edge takes priority over a dead-time expiry in the same cycle
      if (load) begin
         mag_d = smag_q;
         sat_d = ssat_q;
         if (smag_q == 16'd0) begin
            state_d = ST_IDLE;
            dead_d  = '0;
         end else if ((sdir_q != dir_q) && (state_q != ST_IDLE)) begin
            state_d = ST_DEAD;
            dead_d  = DEAD_LD;
            dir_d   = sdir_q;
         end else begin
            state_d = ST_DRIVE;
            dead_d  = '0;
            dir_d   = sdir_q;
         end
      end

      pwm_a_d = (state_q == ST_DRIVE) && (cnt < mag_q) && !dir_q;
      pwm_b_d = (state_q == ST_DRIVE) && (cnt < mag_q) && dir_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         smag_q  <= '0;
         sdir_q  <= 1'b0;
         ssat_q  <= 1'b0;
         mag_q   <= '0;
         dir_q   <= 1'b0;
         sat_q   <= 1'b0;
         dead_q  <= '0;
         pwm_a_q <= 1'b0;
         pwm_b_q <= 1'b0;
      end else begin
         state_q <= state_d;
         smag_q  <= smag_d;
         sdir_q  <= sdir_d;
         ssat_q  <= ssat_d;
         mag_q   <= mag_d;
         dir_q   <= dir_d;
         sat_q   <= sat_d;
         dead_q  <= dead_d;
         pwm_a_q <= pwm_a_d;
         pwm_b_q <= pwm_b_d;
      end
   end

   assign bus.pwm_a        = pwm_a_q;
   assign bus.pwm_b        = pwm_b_q;
   assign bus.dir          = dir_q;
   assign bus.sat_flag     = sat_q;
   assign bus.period_start = period_start;

endmodule

// File: tb/tb_pwm_motor_driver.sv
// Bench for pwm_motor_driver: per-period expectations are queued as commands
// are issued and compared when the monitor closes each PWM period.
module tb_pwm_motor_driver;

   localparam int PERIOD   = 100;
   localparam int MAX_DUTY = 95;
   localparam int DEADTIME = 4;

   typedef struct {
      int a_hi;
      int b_hi;
      int dir;
      int sat;
      int first;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   exp_t sb_q[$];

   int a_cnt, b_cnt, idx, first_hi, snap_dir, snap_sat;

   pwm_motor_driver_if bus();

   pwm_motor_driver #(
      .PERIOD  (PERIOD),
      .MAX_DUTY(MAX_DUTY),
      .DEADTIME(DEADTIME)
   ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp_v, $time);
      end
   endtask

   // Window covers the gate outputs produced for cnt 0..PERIOD-1 of one period.
   always @(negedge clk) begin
      chk("excl", int'(bus.pwm_a & bus.pwm_b), 0);
      if (!rst_n) begin
         a_cnt = 0; b_cnt = 0; idx = 0; first_hi = 0;
      end else begin
         idx++;
         a_cnt += int'(bus.pwm_a);
         b_cnt += int'(bus.pwm_b);
         if (first_hi == 0 && (bus.pwm_a || bus.pwm_b)) first_hi = idx;
         if (idx == 50) begin
            snap_dir = int'(bus.dir);
            snap_sat = int'(bus.sat_flag);
         end
         if (bus.period_start) begin
            if (sb_q.size() > 0) begin
               exp_t e;
               e = sb_q.pop_front();
               chk("a_hi",  a_cnt,    e.a_hi);
               chk("b_hi",  b_cnt,    e.b_hi);
               chk("dir",   snap_dir, e.dir);
               chk("sat",   snap_sat, e.sat);
               chk("first", first_hi, e.first);
            end
            a_cnt = 0; b_cnt = 0; idx = 0; first_hi = 0;
         end
      end
   end

   task automatic wait_period();
      int n;
      n = 0;
      while (!bus.period_start && n < 3 * PERIOD) begin
         @(posedge clk); #1;
         n++;
      end
      chk("period_timeout", int'(bus.period_start), 1);
      @(negedge clk); #1;
   endtask

   task automatic expect_period(input int a, input int b, input int d, input int s,
                                input int f);
      exp_t e;
      wait_period();
      e.a_hi = a; e.b_hi = b; e.dir = d; e.sat = s; e.first = f;
      sb_q.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic send_cmd(input int v);
      bus.cmd_in    = 16'(v);
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_pwm_a"}, int'(bus.pwm_a), 0);
      chk({tag, "_pwm_b"}, int'(bus.pwm_b), 0);
      chk({tag, "_dir"},   int'(bus.dir), 0);
      chk({tag, "_sat"},   int'(bus.sat_flag), 0);
      chk({tag, "_pstart"}, int'(bus.period_start), 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      a_cnt = 0; b_cnt = 0; idx = 0; first_hi = 0; snap_dir = 0; snap_sat = 0;
      rst_n         = 1'b0;
      bus.cmd_in    = '0;
      bus.cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst0");
      rst_n = 1'b1;

      // IDLE to forward 25
      expect_period(0, 0, 0, 0, 0);
      send_cmd(25);
      expect_period(25, 0, 0, 0, 1);
      expect_period(25, 0, 0, 0, 1);
      // reversal to -40 with dead time
      send_cmd(-40);
      expect_period(0, 36, 1, 0, 5);
      expect_period(0, 40, 1, 0, 1);
      // zero command: IDLE, direction sticky
      send_cmd(0);
      expect_period(0, 0, 1, 0, 0);
      // saturated forward from IDLE, then most negative command
      send_cmd(500);
      expect_period(95, 0, 0, 1, 1);
      send_cmd(32'h0000_8000);
      expect_period(0, 91, 1, 1, 5);
      expect_period(0, 95, 1, 1, 1);

      // mid-period reset at cnt = 50 with a command that must be ignored
      wait_period();
      repeat (49) @(posedge clk);
      #1;
      rst_n         = 1'b0;
      bus.cmd_in    = 16'd30;
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("rst_mid");
      rst_n         = 1'b1;
      bus.cmd_valid = 1'b0;

      expect_period(0, 0, 0, 0, 0);
      expect_period(0, 0, 0, 0, 0);
      send_cmd(30);

      // command coinciding with the load edge waits one extra period
      begin
         exp_t e;
         wait_period();
         e.a_hi = 30; e.b_hi = 0; e.dir = 0; e.sat = 0; e.first = 1;
         sb_q.push_back(e);
         repeat (99) @(posedge clk);
         #1;
         bus.cmd_in    = 16'd10;
         bus.cmd_valid = 1'b1;
         @(posedge clk); #1;
         bus.cmd_valid = 1'b0;
      end
      expect_period(30, 0, 0, 0, 1);
      expect_period(10, 0, 0, 0, 1);
      wait_period();
      chk("sb_drained", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
